// File: rtl/da_fir_engine.sv
// Bit-serial distributed-arithmetic core for a 4-tap FIR: builds a 16-entry
// partial-sum LUT from four coefficients, then computes one signed dot product per start.
module da_fir_engine #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int LUT_W  = COEF_W + 2,
  parameter int OUT_W  = DATA_W + COEF_W + 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_coef_we,
  input  logic [1:0]            i_coef_idx,
  input  logic [COEF_W-1:0]     i_coef_data,
  input  logic                  i_cload,
  input  logic                  i_start,
  input  logic [4*DATA_W-1:0]   i_taps_in,
  output logic                  o_lut_ready,
  output logic                  o_busy,
  output logic [OUT_W-1:0]      o_y_out,
  output logic                  o_y_valid,
  output logic                  o_overrun
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUILD, S_READY, S_RUN} state_t;

  state_t              r_state, w_state_nxt;
  logic [COEF_W-1:0]   r_coef [4];
  logic [LUT_W-1:0]    r_lut  [16];
  logic [3:0]          r_build_k;
  logic [DATA_W-1:0]   r_tap  [4];
  logic [BIT_W-1:0]    r_bit;
  logic [OUT_W-1:0]    r_acc;
  logic [OUT_W-1:0]    r_y_out;
  logic                r_y_valid;
  logic                r_overrun;

  logic                w_cload_ok;
  logic                w_start_ok;
  logic                w_last_bit;
  logic [LUT_W-1:0]    w_build_sum;
  logic [3:0]          w_lut_addr;
  logic [OUT_W-1:0]    w_term;
  logic [OUT_W-1:0]    w_acc_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value held (which would infer a latch).
  always_comb begin
    w_state_nxt = r_state;
    w_cload_ok  = 1'b0;
    w_start_ok  = 1'b0;
    w_last_bit  = (r_bit == BIT_W'(DATA_W - 1));
    unique case (r_state)
      S_IDLE: begin
        if (i_cload) begin
          w_cload_ok  = 1'b1;
          w_state_nxt = S_BUILD;
        end
      end
      S_BUILD: begin
        if (r_build_k == 4'hF) w_state_nxt = S_READY;
      end
      S_READY: begin
        if (i_cload) begin
          w_cload_ok  = 1'b1;
          w_state_nxt = S_BUILD;
        end else if (i_start) begin
          w_start_ok  = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last_bit) w_state_nxt = S_READY;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Coefficients are frozen while the LUT is being built from them.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) r_coef[i] <= '0;
    end else if (i_coef_we && r_state != S_BUILD) begin
      r_coef[i_coef_idx] <= i_coef_data;
    end
  end

  always_comb begin
    w_build_sum = '0;
    for (int i = 0; i < 4; i++) begin
      if (r_build_k[i])
        w_build_sum = w_build_sum +
                      {{(LUT_W-COEF_W){r_coef[i][COEF_W-1]}}, r_coef[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn)                r_build_k <= '0;
    else if (r_state == S_BUILD) r_build_k <= r_build_k + 4'd1;
    else                        r_build_k <= '0;
  end

  // NOTE: the LUT has no reset; its contents are only trusted once a build
  // has completed, which o_lut_ready already tracks.
  always_ff @(posedge clk) begin
    if (r_state == S_BUILD) r_lut[r_build_k] <= w_build_sum;
  end

  // One bit-plane per cycle: the LUT address gathers bit b of every tap.
  always_comb begin
    for (int i = 0; i < 4; i++) w_lut_addr[i] = r_tap[i][r_bit];
    w_term    = {{(OUT_W-LUT_W){r_lut[w_lut_addr][LUT_W-1]}}, r_lut[w_lut_addr]} << r_bit;
    w_acc_nxt = w_last_bit ? (r_acc - w_term) : (r_acc + w_term);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) r_tap[i] <= '0;
      r_bit     <= '0;
      r_acc     <= '0;
      r_y_out   <= '0;
      r_y_valid <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_y_valid <= 1'b0;
      if (w_start_ok) begin
        for (int i = 0; i < 4; i++) r_tap[i] <= i_taps_in[i*DATA_W +: DATA_W];
        r_bit <= '0;
        r_acc <= '0;
      end
      if (r_state == S_RUN) begin
        if (w_last_bit) begin
          r_y_out   <= w_acc_nxt;
          r_y_valid <= 1'b1;
        end else begin
          r_acc <= w_acc_nxt;
          r_bit <= r_bit + BIT_W'(1);
        end
        if (i_start) r_overrun <= 1'b1;
      end
      if (w_cload_ok) r_overrun <= 1'b0;
    end
  end

  assign o_lut_ready = (r_state == S_READY) || (r_state == S_RUN);
  assign o_busy      = (r_state == S_RUN);
  assign o_y_out     = r_y_out;
  assign o_y_valid   = r_y_valid;
  assign o_overrun   = r_overrun;

endmodule
